// File: rtl/edc_pkg.sv
// Shared SECDED Hamming(39,32) definitions: widths, data-bit position map,
// check-bit generator and word classification.
package edc_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned EDC_W  = 7;
   localparam int unsigned HAM_W  = 6;
   localparam int unsigned POS_W  = 6;

   typedef logic [POS_W-1:0] pos_t;

   typedef enum logic [1:0] {
      EDC_CLEAN = 2'd0,
      EDC_CE    = 2'd1,
      EDC_UE    = 2'd2
   } edc_class_e;

   typedef struct packed {
      edc_class_e        cls;
      logic [EDC_W-1:0]  syn;
      logic [DATA_W-1:0] data;
   } edc_dec_t;

   // Codeword position of d0..d31 (powers of two are reserved for check bits).
   localparam pos_t DATA_POS [DATA_W] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
      6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
      6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
   };

   function automatic logic [HAM_W-1:0] edc_ham(input logic [DATA_W-1:0] data);
      logic [HAM_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_W; i++) begin
         for (int k = 0; k < HAM_W; k++) begin
            if (DATA_POS[i][k]) c[k] = c[k] ^ data[i];
         end
      end
      return c;
   endfunction

   function automatic logic [EDC_W-1:0] edc_gen(input logic [DATA_W-1:0] data);
      logic [HAM_W-1:0] c;
      c = edc_ham(data);
      return {^{data, c}, c};
   endfunction

endpackage

// File: rtl/edc_checker_if.sv
// Memory read-path input, checked-word output and error status sideband.
interface edc_checker_if #(
   parameter int unsigned CNT_WIDTH = 16
) ();
   import edc_pkg::*;

   logic                 i_valid;
   logic                 o_ready;
   logic [DATA_W-1:0]    i_data;
   logic [EDC_W-1:0]     i_edc;
   logic [ADDR_W-1:0]    i_addr;
   logic                 o_valid;
   logic                 i_ready;
   logic [DATA_W-1:0]    o_data;
   logic                 o_ce;
   logic                 o_ue;
   logic                 i_clr;
   logic [CNT_WIDTH-1:0] o_ce_count;
   logic [CNT_WIDTH-1:0] o_ue_count;
   logic [ADDR_W-1:0]    o_err_addr;
   logic [EDC_W-1:0]     o_err_syn;
   logic                 o_irq;

   modport slave (
      input  i_valid, i_data, i_edc, i_addr, i_ready, i_clr,
      output o_ready, o_valid, o_data, o_ce, o_ue,
             o_ce_count, o_ue_count, o_err_addr, o_err_syn, o_irq
   );

   modport master (
      output i_valid, i_data, i_edc, i_addr, i_ready, i_clr,
      input  o_ready, o_valid, o_data, o_ce, o_ue,
             o_ce_count, o_ue_count, o_err_addr, o_err_syn, o_irq
   );
endinterface

// File: rtl/edc_syndrome.sv
// Combinational SECDED decode: syndrome, overall parity, class and corrected data.
module edc_syndrome import edc_pkg::*; #(
   parameter int unsigned EDC_CORRECT = 1
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [EDC_W-1:0]  edc_i,
   output edc_dec_t          dec_c_o
);

   logic [HAM_W-1:0]  ham_c;
   logic [HAM_W-1:0]  syn_c;
   logic              par_c;
   logic              syn_pow2_c;
   logic [DATA_W-1:0] flip_c;

   assign ham_c      = edc_ham(data_i);
   assign syn_c      = ham_c ^ edc_i[HAM_W-1:0];
   assign par_c      = ^{data_i, edc_i};
   assign syn_pow2_c = (syn_c & (syn_c - HAM_W'(1))) == '0;

   // One-hot mask of the data bit at the syndrome position; empty for s > 38.
   always_comb begin
      flip_c = '0;
      for (int i = 0; i < DATA_W; i++) begin
         flip_c[i] = (syn_c == DATA_POS[i]);
      end
   end

   always_comb begin
      dec_c_o.cls  = EDC_UE;
      dec_c_o.syn  = {par_c, syn_c};
      dec_c_o.data = data_i;
      if (!par_c && (syn_c == '0)) begin
         dec_c_o.cls = EDC_CLEAN;
      end else if (par_c && (syn_pow2_c || (|flip_c))) begin
         dec_c_o.cls = EDC_CE;
         if (EDC_CORRECT != 0) dec_c_o.data = data_i ^ flip_c;
      end
   end

endmodule

// File: rtl/edc_checker.sv
// Read-side EDC checker: decode, one output register stage with valid/ready,
// saturating CE/UE counters, error-address log and sticky interrupt.
module edc_checker import edc_pkg::*; #(
   parameter int unsigned WB_DWIDTH   = 32,
   parameter int unsigned EDC_WIDTH   = 7,
   parameter int unsigned EDC_CORRECT = 1,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   edc_checker_if.slave bus
);

   edc_dec_t             dec_c;
   logic                 ready_c;
   logic                 xfer_c;
   logic                 is_ce_c;
   logic                 is_ue_c;

   logic                 valid_q,  valid_d;
   logic [WB_DWIDTH-1:0] data_q,   data_d;
   logic                 ce_q,     ce_d;
   logic                 ue_q,     ue_d;
   logic [CNT_WIDTH-1:0] ce_cnt_q, ce_cnt_d;
   logic [CNT_WIDTH-1:0] ue_cnt_q, ue_cnt_d;
   logic [ADDR_W-1:0]    addr_q,   addr_d;
   logic [EDC_WIDTH-1:0] syn_q,    syn_d;
   logic                 irq_q,    irq_d;
   logic                 lock_q,   lock_d;

   edc_syndrome #(
      .EDC_CORRECT (EDC_CORRECT)
   ) u_syndrome (
      .data_i  (bus.i_data),
      .edc_i   (bus.i_edc),
      .dec_c_o (dec_c)
   );

   assign ready_c = !valid_q || bus.i_ready;
   assign xfer_c  = bus.i_valid && ready_c;
   assign is_ce_c = xfer_c && (dec_c.cls == EDC_CE);
   assign is_ue_c = xfer_c && (dec_c.cls == EDC_UE);

   // Output stage: load on transfer, drain when the consumer takes the word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ce_d    = ce_q;
      ue_d    = ue_q;
      if (xfer_c) begin
         valid_d = 1'b1;
         data_d  = dec_c.data;
         ce_d    = is_ce_c;
         ue_d    = is_ue_c;
      end else if (bus.i_ready) begin
         valid_d = 1'b0;
      end
   end

   // Status: clear applies first so an error in the same cycle survives it.
   always_comb begin
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      addr_d   = addr_q;
      syn_d    = syn_q;
      irq_d    = irq_q;
      lock_d   = lock_q;
      if (bus.i_clr) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
         addr_d   = '0;
         syn_d    = '0;
         irq_d    = 1'b0;
         lock_d   = 1'b0;
      end
      if (is_ce_c && (ce_cnt_d != '1)) ce_cnt_d = ce_cnt_d + CNT_WIDTH'(1);
      if (is_ue_c && (ue_cnt_d != '1)) ue_cnt_d = ue_cnt_d + CNT_WIDTH'(1);
      if (is_ue_c) begin
         addr_d = bus.i_addr;
         syn_d  = dec_c.syn;
         lock_d = 1'b1;
      end else if (is_ce_c && !lock_d) begin
         addr_d = bus.i_addr;
         syn_d  = dec_c.syn;
      end
      if (is_ce_c || is_ue_c) irq_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         ce_q     <= 1'b0;
         ue_q     <= 1'b0;
         ce_cnt_q <= '0;
         ue_cnt_q <= '0;
         addr_q   <= '0;
         syn_q    <= '0;
         irq_q    <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         ce_q     <= ce_d;
         ue_q     <= ue_d;
         ce_cnt_q <= ce_cnt_d;
         ue_cnt_q <= ue_cnt_d;
         addr_q   <= addr_d;
         syn_q    <= syn_d;
         irq_q    <= irq_d;
         lock_q   <= lock_d;
      end
   end

   assign bus.o_ready    = ready_c;
   assign bus.o_valid    = valid_q;
   assign bus.o_data     = data_q;
   assign bus.o_ce       = ce_q;
   assign bus.o_ue       = ue_q;
   assign bus.o_ce_count = ce_cnt_q;
   assign bus.o_ue_count = ue_cnt_q;
   assign bus.o_err_addr = addr_q;
   assign bus.o_err_syn  = syn_q;
   assign bus.o_irq      = irq_q;

endmodule

// File: tb/tb_edc_checker.sv
// Bench for edc_checker: directed cases plus random single/double bit errors
// against a position-based Hamming reference model.
module tb_edc_checker;
   import edc_pkg::*;

   localparam int unsigned CW   = 16;
   localparam int          CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   edc_checker_if #(.CNT_WIDTH(CW)) bus ();
   edc_checker_if #(.CNT_WIDTH(CW)) bus_nc ();

   edc_checker #(.EDC_CORRECT(1), .CNT_WIDTH(CW)) dut (
      .i_clk (clk), .i_rst_n (rst_n), .bus (bus)
   );
   edc_checker #(.EDC_CORRECT(0), .CNT_WIDTH(CW)) dut_nc (
      .i_clk (clk), .i_rst_n (rst_n), .bus (bus_nc)
   );

   assign bus_nc.i_valid = bus.i_valid;
   assign bus_nc.i_data  = bus.i_data;
   assign bus_nc.i_edc   = bus.i_edc;
   assign bus_nc.i_addr  = bus.i_addr;
   assign bus_nc.i_ready = bus.i_ready;
   assign bus_nc.i_clr   = bus.i_clr;

   always #5 clk = ~clk;

   // Reference model state
   int          m_ce, m_ue;
   logic [31:0] m_addr;
   logic [6:0]  m_syn;
   logic        m_irq, m_lock;
   logic        e_valid, e_ce, e_ue;
   logic [31:0] e_data;

   // Check bits from the classic rule: XOR of the positions of all set data bits.
   function automatic logic [6:0] tb_encode(input logic [31:0] d);
      int di = 0;
      int s  = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[di]) s = s ^ pos;
            di++;
         end
      end
      return {^d ^ ^s[5:0], s[5:0]};
   endfunction

   // Lay the 39 received bits out as a codeword; syndrome = XOR of set positions.
   function automatic void tb_decode(input logic [31:0] d, input logic [6:0] e,
                                     output int cls, output logic [31:0] cd,
                                     output logic [6:0] syn);
      logic cw [1:38];
      int   di, k, s;
      logic par;
      di = 0; k = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) == 0) begin cw[pos] = e[k]; k++; end
         else begin cw[pos] = d[di]; di++; end
      end
      s = 0; par = e[6];
      for (int pos = 1; pos <= 38; pos++) begin
         if (cw[pos]) s = s ^ pos;
         par = par ^ cw[pos];
      end
      if (s == 0 && !par) cls = 0;
      else if (par && s <= 38) begin
         cls = 1;
         if (s != 0) cw[s] = ~cw[s];
      end else cls = 2;
      di = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin cd[di] = cw[pos]; di++; end
      end
      syn = {par, s[5:0]};
   endfunction

   task automatic model_reset();
      m_ce = 0; m_ue = 0; m_addr = '0; m_syn = '0; m_irq = 1'b0; m_lock = 1'b0;
      e_valid = 1'b0; e_data = '0; e_ce = 1'b0; e_ue = 1'b0;
   endtask

   task automatic model_cycle(input logic xfer, input logic [31:0] d, input logic [6:0] e,
                              input logic [31:0] a, input logic clr);
      int          cls;
      logic [31:0] cd;
      logic [6:0]  syn;
      if (clr) begin
         m_ce = 0; m_ue = 0; m_addr = '0; m_syn = '0; m_irq = 1'b0; m_lock = 1'b0;
      end
      if (xfer) begin
         tb_decode(d, e, cls, cd, syn);
         e_valid = 1'b1; e_data = cd; e_ce = (cls == 1); e_ue = (cls == 2);
         if (cls == 1) begin
            if (m_ce < CMAX) m_ce++;
            if (!m_lock) begin m_addr = a; m_syn = syn; end
            m_irq = 1'b1;
         end
         if (cls == 2) begin
            if (m_ue < CMAX) m_ue++;
            m_addr = a; m_syn = syn; m_lock = 1'b1; m_irq = 1'b1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string t);
      check({t, ".o_valid"}, 64'(bus.o_valid), 64'(e_valid));
      check({t, ".o_data"},  64'(bus.o_data),  64'(e_data));
      check({t, ".o_ce"},    64'(bus.o_ce),    64'(e_ce));
      check({t, ".o_ue"},    64'(bus.o_ue),    64'(e_ue));
   endtask

   task automatic check_status(input string t);
      check({t, ".ce_count"}, 64'(bus.o_ce_count), 64'(m_ce));
      check({t, ".ue_count"}, 64'(bus.o_ue_count), 64'(m_ue));
      check({t, ".err_addr"}, 64'(bus.o_err_addr), 64'(m_addr));
      check({t, ".err_syn"},  64'(bus.o_err_syn),  64'(m_syn));
      check({t, ".irq"},      64'(bus.o_irq),      64'(m_irq));
   endtask

   // One accepted word (caller guarantees o_ready is high at the edge).
   task automatic step(input logic [31:0] d, input logic [6:0] e,
                       input logic [31:0] a, input logic clr);
      bus.i_valid = 1'b1; bus.i_data = d; bus.i_edc = e; bus.i_addr = a; bus.i_clr = clr;
      @(posedge clk);
      model_cycle(1'b1, d, e, a, clr);
      #1;
      bus.i_valid = 1'b0; bus.i_clr = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: observed still running, expected finished");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [31:0] d, a, wa, wb;
      logic [6:0]  e, ea, eb;
      logic [38:0] cw;
      int          n, b1, b2;
      logic        clr;

      bus.i_valid = 1'b0; bus.i_data = '0; bus.i_edc = '0; bus.i_addr = '0;
      bus.i_ready = 1'b1; bus.i_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      check("reset.o_ready", 64'(bus.o_ready), 64'd1);
      check_out("reset");
      check_status("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean word
      step(32'hDEADBEEF, tb_encode(32'hDEADBEEF), 32'h0, 1'b0);
      check("clean.o_data", 64'(bus.o_data), 64'hDEADBEEF);
      check_out("clean");
      check_status("clean");

      // d5 flipped: corrected by one instance, passed through by the other
      step(32'hDEADBECF, tb_encode(32'hDEADBEEF), 32'h100, 1'b0);
      check("ce_d5.o_data", 64'(bus.o_data), 64'hDEADBEEF);
      check("ce_d5.ce_count", 64'(bus.o_ce_count), 64'd1);
      check("ce_d5.err_addr", 64'(bus.o_err_addr), 64'h100);
      check("ce_d5.nc_data", 64'(bus_nc.o_data), 64'hDEADBECF);
      check("ce_d5.nc_ce", 64'(bus_nc.o_ce), 64'd1);
      check_out("ce_d5");
      check_status("ce_d5");

      // Double error, then a later CE must not overwrite the UE log
      step(32'h3, tb_encode(32'h0), 32'h200, 1'b0);
      check("ue.o_ue", 64'(bus.o_ue), 64'd1);
      check("ue.ue_count", 64'(bus.o_ue_count), 64'd1);
      check("ue.err_syn", 64'(bus.o_err_syn), 64'h06);
      check_status("ue");
      step(32'h1, tb_encode(32'h0), 32'h300, 1'b0);
      check("ce_locked.err_addr", 64'(bus.o_err_addr), 64'h200);
      check_out("ce_locked");
      check_status("ce_locked");

      // Check-bit and overall-parity-bit errors: data untouched
      step(32'h12345678, tb_encode(32'h12345678) ^ 7'h04, 32'h400, 1'b0);
      check("ce_cbit.o_data", 64'(bus.o_data), 64'h12345678);
      check_out("ce_cbit");
      step(32'h12345678, tb_encode(32'h12345678) ^ 7'h40, 32'h404, 1'b0);
      check_out("ce_pbit");
      check_status("ce_pbit");

      // Random words with 0, 1 or 2 flipped codeword bits, occasional clears
      for (int it = 0; it < 300; it++) begin
         d  = $urandom;
         a  = $urandom;
         n  = $urandom_range(0, 2);
         b1 = $urandom_range(0, 38);
         b2 = (b1 + $urandom_range(1, 38)) % 39;
         cw = {tb_encode(d), d};
         if (n >= 1) cw[b1] = ~cw[b1];
         if (n == 2) cw[b2] = ~cw[b2];
         clr = ($urandom_range(0, 15) == 0);
         step(cw[31:0], cw[38:32], a, clr);
         check_out("rnd");
         check_status("rnd");
         if (n < 2) check("rnd.truth", 64'(bus.o_data), 64'(d));
      end

      // Backpressure: first word held for 5 cycles, second taken when ready rises
      @(posedge clk); #1; e_valid = 1'b0;
      check("stall.drain", 64'(bus.o_valid), 64'd0);
      wa = $urandom; ea = tb_encode(wa) ^ 7'h08;
      wb = $urandom; eb = tb_encode(wb);
      bus.i_ready = 1'b0;
      step(wa, ea, 32'h500, 1'b0);
      bus.i_valid = 1'b1; bus.i_data = wb; bus.i_edc = eb; bus.i_addr = 32'h504;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("stall.o_ready", 64'(bus.o_ready), 64'd0);
         check_out("stall");
         check_status("stall");
      end
      bus.i_ready = 1'b1;
      #1;
      check("stall.release_ready", 64'(bus.o_ready), 64'd1);
      @(posedge clk);
      model_cycle(1'b1, wb, eb, 32'h504, 1'b0);
      #1;
      bus.i_valid = 1'b0;
      check("stall.second", 64'(bus.o_data), 64'(wb));
      check_out("stall_b");
      check_status("stall_b");
      @(posedge clk); #1; e_valid = 1'b0;
      check("stall.no_dup", 64'(bus.o_valid), 64'd0);

      // Saturation of the CE counter
      bus.i_clr = 1'b1;
      @(posedge clk); model_cycle(1'b0, '0, '0, '0, 1'b1); #1;
      bus.i_clr = 1'b0;
      check_status("clr");
      bus.i_valid = 1'b1; bus.i_data = 32'h1; bus.i_edc = tb_encode(32'h0); bus.i_addr = 32'h600;
      repeat (CMAX) begin
         @(posedge clk);
         model_cycle(1'b1, 32'h1, tb_encode(32'h0), 32'h600, 1'b0);
      end
      #1;
      check("sat.ce_count", 64'(bus.o_ce_count), 64'hFFFF);
      step(32'h1, tb_encode(32'h0), 32'h604, 1'b0);
      check("sat.hold", 64'(bus.o_ce_count), 64'hFFFF);
      check_status("sat");

      // Clear colliding with a UE: error wins
      step(32'h3, tb_encode(32'h0), 32'h700, 1'b1);
      check("clr_ue.ue_count", 64'(bus.o_ue_count), 64'd1);
      check("clr_ue.ce_count", 64'(bus.o_ce_count), 64'd0);
      check("clr_ue.irq", 64'(bus.o_irq), 64'd1);
      check_status("clr_ue");

      // Asynchronous reset with a word held
      check("arst.pre_valid", 64'(bus.o_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst.o_valid", 64'(bus.o_valid), 64'd0);
      check("arst.o_ready", 64'(bus.o_ready), 64'd1);
      check_out("arst");
      check_status("arst");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      d = $urandom;
      step(d, tb_encode(d), 32'h800, 1'b0);
      check_out("post_rst");
      check_status("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
